// File: rtl/serial_pattern_sender.sv
// Serialises a captured WIDTH-bit pattern MSB-first onto sdata/sclk for an
// external shift-register chain, then strobes slatch and counts the frame.
module serial_pattern_sender #(
  parameter int WIDTH        = 120,
  parameter int CLK_DIV      = 4,
  parameter int LATCH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             newGo,
  input  logic [WIDTH-1:0] newSW,
  output logic             Ready2Go,
  output logic             sdata,
  output logic             sclk,
  output logic             slatch,
  output logic [7:0]       frameCount
);

  localparam int BIT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CNT_MAX = (CLK_DIV > LATCH_CYCLES) ? CLK_DIV : LATCH_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(LATCH_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_HIGH  = 2'd2,
    S_LATCH = 2'd3
  } state_e;

  state_e             state_q,     state_d;
  logic [WIDTH-1:0]   shift_q,     shift_d;
  logic [BIT_W-1:0]   bit_cnt_q,   bit_cnt_d;
  logic [CNT_W-1:0]   div_cnt_q,   div_cnt_d;
  logic [7:0]         frame_cnt_q, frame_cnt_d;
  logic               ready_q,     ready_d;
  logic               sdata_q,     sdata_d;
  logic               sclk_q,      sclk_d;
  logic               slatch_q,    slatch_d;

  // Next-state logic for the transfer sequencer.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    div_cnt_d   = div_cnt_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (newGo) begin
          shift_d   = newSW;
          bit_cnt_d = BIT_LAST;
          div_cnt_d = '0;
          state_d   = S_SETUP;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_SETUP: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          state_d   = S_HIGH;
        end else begin
          div_cnt_d = div_cnt_q + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (bit_cnt_q == '0) begin
            state_d = S_LATCH;
          end else begin
            shift_d   = shift_q << 1;
            bit_cnt_d = bit_cnt_q - BIT_W'(1);
            state_d   = S_SETUP;
          end
        end else begin
          div_cnt_d = div_cnt_q + CNT_W'(1);
        end
      end
      S_LATCH: begin
        if (div_cnt_q == LATCH_LAST) begin
          div_cnt_d   = '0;
          frame_cnt_d = frame_cnt_q + 8'd1;
          state_d     = S_IDLE;
        end else begin
          div_cnt_d   = div_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        div_cnt_d = '0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so the flops present them in
  // the same cycle the state register enters that state.
  always_comb begin
    ready_d  = 1'b0;
    sdata_d  = 1'b0;
    sclk_d   = 1'b0;
    slatch_d = 1'b0;
    case (state_d)
      S_IDLE:  ready_d = 1'b1;
      S_SETUP: sdata_d = shift_d[WIDTH-1];
      S_HIGH: begin
        sdata_d = shift_d[WIDTH-1];
        sclk_d  = 1'b1;
      end
      S_LATCH: slatch_d = 1'b1;
      default: ready_d = 1'b0;
    endcase
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      div_cnt_q   <= '0;
      frame_cnt_q <= 8'd0;
      ready_q     <= 1'b1;
      sdata_q     <= 1'b0;
      sclk_q      <= 1'b0;
      slatch_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      div_cnt_q   <= div_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      ready_q     <= ready_d;
      sdata_q     <= sdata_d;
      sclk_q      <= sclk_d;
      slatch_q    <= slatch_d;
    end
  end

  assign Ready2Go   = ready_q;
  assign sdata      = sdata_q;
  assign sclk       = sclk_q;
  assign slatch     = slatch_q;
  assign frameCount = frame_cnt_q;

endmodule

// File: tb/tb_serial_pattern_sender.sv
// Randomised bench for serial_pattern_sender: a cycle-position reference model
// plus a receiving-chain model check every output, frame by frame.
module tb_serial_pattern_sender;

  localparam int W  = 120;
  localparam int C  = 4;
  localparam int L  = 2;
  localparam int T  = 1 + 2 * W * C + L;
  localparam int W2 = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          newGo;
  logic [W-1:0]  newSW;
  logic          Ready2Go, sdata, sclk, slatch;
  logic [7:0]    frameCount;

  logic          newGo2;
  logic [W2-1:0] newSW2;
  logic          Ready2Go2, sdata2, sclk2, slatch2;
  logic [7:0]    frameCount2;

  int n_checks = 0;
  int n_errors = 0;
  bit mon_en   = 1'b0;

  always #5 clk = ~clk;

  serial_pattern_sender #(.WIDTH(W), .CLK_DIV(C), .LATCH_CYCLES(L)) dut (
    .clk(clk), .reset(reset), .newGo(newGo), .newSW(newSW),
    .Ready2Go(Ready2Go), .sdata(sdata), .sclk(sclk), .slatch(slatch),
    .frameCount(frameCount)
  );

  serial_pattern_sender #(.WIDTH(W2), .CLK_DIV(1), .LATCH_CYCLES(1)) dut_small (
    .clk(clk), .reset(reset), .newGo(newGo2), .newSW(newSW2),
    .Ready2Go(Ready2Go2), .sdata(sdata2), .sclk(sclk2), .slatch(slatch2),
    .frameCount(frameCount2)
  );

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd_pat();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  task automatic wait_ready(input logic lvl, input int limit, input string tag);
    int n;
    n = 0;
    while (Ready2Go !== lvl && n < limit) begin
      tick();
      n++;
    end
    if (Ready2Go !== lvl) check_val(tag, {127'd0, Ready2Go}, {127'd0, lvl});
  endtask

  // Reference model: frame position p (1..T-1) since acceptance fixes every output.
  bit           m_idle;
  int           m_p;
  logic [W-1:0] m_pat;
  logic [7:0]   m_fc;
  logic [W-1:0] cap;
  int           rises;
  logic         sclk_prev, slatch_prev;
  logic [W2-1:0] cap2;
  int           rises2;
  logic         sclk2_prev, slatch2_prev;

  initial begin
    logic e_ready, e_sclk, e_sdata, e_slatch;
    int ph;
    forever begin
      @(negedge clk);
      if (!mon_en) continue;
      if (reset) begin
        m_idle = 1'b1; m_p = 0; m_fc = 8'd0;
        cap = '0; rises = 0; sclk_prev = 1'b0; slatch_prev = 1'b0;
        cap2 = '0; rises2 = 0; sclk2_prev = 1'b0; slatch2_prev = 1'b0;
        continue;
      end
      e_ready = m_idle; e_sclk = 1'b0; e_sdata = 1'b0; e_slatch = 1'b0;
      if (!m_idle) begin
        ph = m_p - 1;
        if (m_p <= 2 * W * C) begin
          e_sclk  = ((ph / C) % 2) == 1;
          e_sdata = m_pat[W - 1 - ph / (2 * C)];
        end else begin
          e_slatch = 1'b1;
        end
      end
      check_val("ready",  {127'd0, Ready2Go}, {127'd0, e_ready});
      check_val("sclk",   {127'd0, sclk},     {127'd0, e_sclk});
      check_val("sdata",  {127'd0, sdata},    {127'd0, e_sdata});
      check_val("slatch", {127'd0, slatch},   {127'd0, e_slatch});
      check_val("frames", {120'd0, frameCount}, {120'd0, m_fc});

      if (sclk && !sclk_prev) begin
        cap = {cap[W-2:0], sdata};
        rises++;
      end
      if (slatch && !slatch_prev) begin
        check_val("chain_bits",  {8'd0, cap}, {8'd0, m_pat});
        check_val("chain_rises", 128'(rises), 128'(W));
      end
      sclk_prev = sclk; slatch_prev = slatch;

      if (sclk2 && !sclk2_prev) begin
        cap2 = {cap2[W2-2:0], sdata2};
        rises2++;
      end
      if (slatch2 && !slatch2_prev) begin
        check_val("small_chain_bits",  {120'd0, cap2}, {120'd0, newSW2});
        check_val("small_chain_rises", 128'(rises2), 128'(W2));
        rises2 = 0;
      end
      sclk2_prev = sclk2; slatch2_prev = slatch2;

      if (m_idle) begin
        if (newGo) begin
          m_idle = 1'b0; m_p = 1; m_pat = newSW;
          cap = '0; rises = 0;
        end
      end else if (m_p == T - 1) begin
        m_idle = 1'b1; m_p = 0; m_fc = m_fc + 8'd1;
      end else begin
        m_p++;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    reset = 1'b0; newGo = 1'b0; newSW = '0; newGo2 = 1'b0; newSW2 = 8'hA5;
    repeat (3) tick();

    // Reset asserted between edges must take effect without a clock edge.
    #2 reset = 1'b1;
    #1;
    check_val("rst_ready",  {127'd0, Ready2Go}, 128'd1);
    check_val("rst_sdata",  {127'd0, sdata},    128'd0);
    check_val("rst_sclk",   {127'd0, sclk},     128'd0);
    check_val("rst_slatch", {127'd0, slatch},   128'd0);
    check_val("rst_frames", {120'd0, frameCount}, 128'd0);
    mon_en = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();

    // Single frame with only the end bits set.
    newSW = '0;
    newSW[W-1] = 1'b1;
    newSW[0]   = 1'b1;
    newGo = 1'b1;
    tick();
    newGo = 1'b0;
    cyc = 1;
    while (!Ready2Go && cyc < 2000) begin
      tick();
      cyc++;
    end
    check_val("t2_ready_cycle", 128'(cyc), 128'(T));
    check_val("t2_frames", {120'd0, frameCount}, 128'd1);

    // Pattern integrity with newSW disturbed mid-frame.
    newSW = rnd_pat();
    newSW[W-1 -: 32] = 32'hF0F0_A5A5;
    newGo = 1'b1;
    tick();
    newGo = 1'b0;
    repeat (300) tick();
    newSW = ~newSW;
    wait_ready(1'b1, 2000, "t3_timeout");
    check_val("t3_frames", {120'd0, frameCount}, 128'd2);

    // Requests while busy are dropped, not queued.
    newSW = rnd_pat();
    newGo = 1'b1;
    tick();
    newGo = 1'b0;
    for (int i = 1; i < 600; i++) begin
      newGo = (i == 10 || i == 500);
      tick();
    end
    newGo = 1'b0;
    wait_ready(1'b1, 2000, "t4_timeout");
    repeat (5) tick();
    check_val("t4_frames", {120'd0, frameCount}, 128'd3);
    check_val("t4_idle",   {127'd0, Ready2Go},   128'd1);

    // Continuous request: back-to-back frames with one idle cycle each.
    newGo = 1'b1;
    for (int f = 0; f < 3; f++) begin
      cyc = 0;
      while (Ready2Go && cyc < 10) begin
        newSW = rnd_pat(); tick(); cyc++;
      end
      cyc = 0;
      while (!Ready2Go && cyc < 2000) begin
        newSW = rnd_pat(); tick(); cyc++;
      end
      check_val("t5_frame_done", {127'd0, Ready2Go}, 128'd1);
      if (f < 2) begin
        newSW = rnd_pat();
        tick();
        check_val("t5_single_idle", {127'd0, Ready2Go}, 128'd0);
      end else begin
        newGo = 1'b0;
      end
    end
    tick();
    check_val("t5_frames", {120'd0, frameCount}, 128'd6);

    // Reset in the middle of a frame (cycle 400, sclk high).
    newSW = rnd_pat();
    newGo = 1'b1;
    tick();
    newGo = 1'b0;
    repeat (399) tick();
    check_val("t6_sclk_before", {127'd0, sclk}, 128'd1);
    #2 reset = 1'b1;
    #1;
    check_val("t6_ready",  {127'd0, Ready2Go}, 128'd1);
    check_val("t6_sclk",   {127'd0, sclk},     128'd0);
    check_val("t6_slatch", {127'd0, slatch},   128'd0);
    check_val("t6_sdata",  {127'd0, sdata},    128'd0);
    check_val("t6_frames", {120'd0, frameCount}, 128'd0);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    newSW = rnd_pat();
    newGo = 1'b1;
    tick();
    newGo = 1'b0;
    wait_ready(1'b1, 2000, "t6_timeout");
    check_val("t6_frames_after", {120'd0, frameCount}, 128'd1);

    // A few random frames with random gaps and request lengths.
    for (int k = 0; k < 2; k++) begin
      repeat ($urandom_range(0, 5)) tick();
      newSW = rnd_pat();
      newGo = 1'b1;
      repeat ($urandom_range(1, 3)) tick();
      newGo = 1'b0;
      wait_ready(1'b1, 2000, "rand_timeout");
    end
    check_val("rand_frames", {120'd0, frameCount}, 128'd3);

    // Frame counter wrap on the small instance: 256 back-to-back frames.
    newSW2 = 8'hA5;
    newGo2 = 1'b1;
    for (int i = 1; i <= 256; i++) begin
      cyc = 0;
      while (Ready2Go2 && cyc < 50) begin tick(); cyc++; end
      cyc = 0;
      while (!Ready2Go2 && cyc < 50) begin tick(); cyc++; end
      if (i == 256) newGo2 = 1'b0;
      check_val("wrap_frames", {120'd0, frameCount2}, 128'(i % 256));
    end
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
